// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizing for the two-master memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam int RD_LAT_MAX = 4;
  // Counter only has to reach RD_LAT_MAX-1, since WAIT starts counting at zero.
  localparam int WAIT_CNT_W = $clog2(RD_LAT_MAX);

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle: CPU master, DMA master and memory side of the arbiter.
// slave = arbiter view, master = masters/memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );

endinterface

// File: rtl/mem_arbiter_arb2.sv
// Two-request grant logic. MEM_ARBITER_RR_EN selects round-robin on ties;
// undefined gives fixed CPU priority.
module mem_arbiter_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  owner_t     i_owner,
  output logic       o_valid,
  output owner_t     o_gnt
);

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // Grant select: bit 0 = CPU, bit 1 = DMA; only a tie consults the mode.
  always_comb begin
    o_valid = |i_req;
    o_gnt   = OWN_CPU;
    case (i_req)
      2'b01: o_gnt = OWN_CPU;
      2'b10: o_gnt = OWN_DMA;
      2'b11: begin
        if (RR_EN) begin
          o_gnt = (i_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
        end else begin
          o_gnt = OWN_CPU;
        end
      end
      default: o_gnt = OWN_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and DMA accesses onto a single-port memory, one transaction
// per grant. Tie policy set by MEM_ARBITER_RR_EN (see mem_arbiter_arb2).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input logic          clk,
  input logic          resetn,
  mem_arbiter_if.slave bus
);

  localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(RD_LAT - 1);

  state_t              r_state, w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  owner_t              r_owner, w_owner_nxt;
  logic                r_mem_en, w_mem_en_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic [DATA_W-1:0]   r_cpu_rdata, w_cpu_rdata_nxt;
  logic [DATA_W-1:0]   r_dma_rdata, w_dma_rdata_nxt;
  logic                r_cpu_ack, w_cpu_ack_nxt;
  logic                r_dma_ack, w_dma_ack_nxt;
  logic                r_busy, w_busy_nxt;

  logic                w_gnt_valid;
  owner_t              w_gnt;

  mem_arbiter_arb2 u_arb2 (
    .i_req   ({bus.dma_req, bus.cpu_req}),
    .i_owner (r_owner),
    .o_valid (w_gnt_valid),
    .o_gnt   (w_gnt)
  );

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_owner_nxt     = r_owner;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_dma_rdata_nxt = r_dma_rdata;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_owner_nxt  = w_gnt;
          w_mem_en_nxt = 1'b1;
          if (w_gnt == OWN_DMA) begin
            w_mem_we_nxt    = bus.dma_we;
            w_mem_addr_nxt  = bus.dma_addr;
            w_mem_wdata_nxt = bus.dma_wdata;
          end else begin
            w_mem_we_nxt    = bus.cpu_we;
            w_mem_addr_nxt  = bus.cpu_addr;
            w_mem_wdata_nxt = bus.cpu_wdata;
          end
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        // r_mem_we still carries the granted direction during ISSUE.
        if (r_mem_we) begin
          w_state_nxt = DONE;
        end else begin
          w_wait_cnt_nxt = {WAIT_CNT_W{1'b0}};
          w_state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (r_wait_cnt == LAST_WAIT) begin
          if (r_owner == OWN_DMA) begin
            w_dma_rdata_nxt = bus.mem_rdata;
          end else begin
            w_cpu_rdata_nxt = bus.mem_rdata;
          end
          w_state_nxt = DONE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_CNT_W'(1);
          w_state_nxt    = WAIT;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt    = (w_state_nxt != IDLE);
    w_cpu_ack_nxt = (w_state_nxt == DONE) && (w_owner_nxt == OWN_CPU);
    w_dma_ack_nxt = (w_state_nxt == DONE) && (w_owner_nxt == OWN_DMA);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_wait_cnt  <= {WAIT_CNT_W{1'b0}};
      r_owner     <= OWN_DMA;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
      r_cpu_rdata <= {DATA_W{1'b0}};
      r_dma_rdata <= {DATA_W{1'b0}};
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_owner     <= w_owner_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_dma_rdata <= w_dma_rdata_nxt;
      r_cpu_ack   <= w_cpu_ack_nxt;
      r_dma_ack   <= w_dma_ack_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.dma_rdata = r_dma_rdata;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.dma_ack   = r_dma_ack;
  assign bus.busy      = r_busy;
  assign bus.owner     = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural RD_LAT memory model.
// Expected tie order follows MEM_ARBITER_RR_EN as compiled.
module tb_mem_arbiter;

  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Memory model: data appears RD_LAT cycles after the enable cycle.
  logic [7:0] mem [0:65535] = '{default: 8'h00};
  logic [7:0] rd_pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    rd_pipe[0] <= mem[bus.mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  int cyc = 0;
  int t0  = 0;
  int n_checks = 0;
  int n_fail   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         port;   // 0 = CPU, 1 = DMA
    bit         rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc - t0);
    end
  endtask

  task automatic expect_ack(bit port, bit rd, logic [7:0] data, int lat);
    exp_t e;
    e.port = port; e.rd = rd; e.data = data; e.cyc = t0 + lat;
    sb.push_back(e);
  endtask

  // Every acknowledge is matched against the oldest expectation.
  always @(negedge clk) begin
    if (resetn === 1'b1 && (bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1)) begin
      if (sb.size() == 0) begin
        check_val("spurious_ack", {30'd0, bus.dma_ack, bus.cpu_ack}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("ack_port", {30'd0, bus.dma_ack, bus.cpu_ack}, e.port ? 32'd2 : 32'd1);
        check_val("ack_cycle", cyc - t0, e.cyc - t0);
        if (e.rd) check_val("rdata", {24'd0, (e.port ? bus.dma_rdata : bus.cpu_rdata)}, {24'd0, e.data});
      end
    end
  end

  task automatic start();
    @(posedge clk); #1;
    t0 = cyc;
  endtask

  task automatic txn(bit port, bit we, logic [15:0] a, logic [7:0] d);
    int n = 0;
    bit got = 1'b0;
    if (port) begin
      bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d; bus.dma_req = 1'b1;
    end else begin
      bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_req = 1'b1;
    end
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      got = port ? bus.dma_ack : bus.cpu_ack;
    end
    if (!got) check_val("txn_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (port) bus.dma_req = 1'b0; else bus.cpu_req = 1'b0;
  endtask

  task automatic held_reads(int n_acks);
    int seen = 0;
    int n = 0;
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0200;
    bus.dma_we = 1'b0; bus.dma_addr = 16'h8000;
    bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
    while (seen < n_acks && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1) seen++;
    end
    if (seen < n_acks) check_val("held_timeout", seen, n_acks);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 16'h0000; bus.dma_wdata = 8'h00;
    apply_reset();

    // Reset during a CPU read WAIT abandons it without an ack.
    start();
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0; bus.cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_outputs", {27'd0, bus.mem_en, bus.mem_we, bus.cpu_ack, bus.dma_ack, bus.busy}, 32'd0);
    check_val("rst_owner", {31'd0, bus.owner}, 32'd1);
    check_val("rst_data", {bus.mem_addr, bus.mem_wdata, bus.cpu_rdata}, 32'd0);
    check_val("rst_dma_rdata", {24'd0, bus.dma_rdata}, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    start();
    expect_ack(1'b0, 1'b1, 8'h00, 3);
    txn(1'b0, 1'b0, 16'h0000, 8'h00);

    // CPU write then read back.
    start();
    expect_ack(1'b0, 1'b0, 8'h00, 2);
    fork
      txn(1'b0, 1'b1, 16'h0200, 8'hA5);
      begin
        @(negedge clk);
        @(negedge clk);
        check_val("issue_en_we", {30'd0, bus.mem_en, bus.mem_we}, 32'd3);
        check_val("issue_addr_data", {8'd0, bus.mem_addr, bus.mem_wdata}, 32'h0002_00A5);
      end
    join
    check_val("wr_keeps_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
    start();
    expect_ack(1'b0, 1'b1, 8'hA5, 3);
    txn(1'b0, 1'b0, 16'h0200, 8'h00);

    // DMA write, CPU reads it back.
    start();
    expect_ack(1'b1, 1'b0, 8'h00, 2);
    txn(1'b1, 1'b1, 16'h8000, 8'h3C);
    check_val("wr_keeps_dma_rdata", {24'd0, bus.dma_rdata}, 32'd0);
    start();
    expect_ack(1'b0, 1'b1, 8'h3C, 3);
    fork
      txn(1'b0, 1'b0, 16'h8000, 8'h00);
      begin
        @(negedge clk);
        @(negedge clk);
        check_val("read_owner", {31'd0, bus.owner}, 32'd0);
        check_val("read_busy", {31'd0, bus.busy}, 32'd1);
      end
    join

    // Simultaneous reads, one transaction per master; owner is CPU here.
    start();
`ifdef MEM_ARBITER_RR_EN
    expect_ack(1'b1, 1'b1, 8'h3C, 3);
    expect_ack(1'b0, 1'b1, 8'hA5, 7);
`else
    expect_ack(1'b0, 1'b1, 8'hA5, 3);
    expect_ack(1'b1, 1'b1, 8'h3C, 7);
`endif
    fork
      txn(1'b0, 1'b0, 16'h0200, 8'h00);
      txn(1'b1, 1'b0, 16'h8000, 8'h00);
    join
`ifdef MEM_ARBITER_RR_EN
    check_val("addr_hold", {16'd0, bus.mem_addr}, 32'h0200);
`else
    check_val("addr_hold", {16'd0, bus.mem_addr}, 32'h8000);
`endif

    // Both held for four reads starting from reset owner.
    apply_reset();
    check_val("rst2_owner", {31'd0, bus.owner}, 32'd1);
    start();
`ifdef MEM_ARBITER_RR_EN
    expect_ack(1'b0, 1'b1, 8'hA5, 3);
    expect_ack(1'b1, 1'b1, 8'h3C, 7);
    expect_ack(1'b0, 1'b1, 8'hA5, 11);
    expect_ack(1'b1, 1'b1, 8'h3C, 15);
`else
    for (int k = 0; k < 4; k++) expect_ack(1'b0, 1'b1, 8'hA5, 3 + 4 * k);
`endif
    held_reads(4);

    repeat (6) @(posedge clk);
    check_val("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
